uart_host_ctrl: RTL and testbench



---
 rtl/uart_host_pkg.sv | 17 +
 rtl/uart_host_satcnt.sv | 24 ++
 rtl/uart_host_ctrl.sv | 176 +++++++++++++++++
 tb/tb_uart_host_ctrl.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_host_pkg.sv
// Shared types and constants for the CoreUART host-side initiator.
package uart_host_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StRead,
    StHold
  } state_e;

  // Idle cycles after each UART access before status is trusted again.
  localparam int unsigned HoldoffDefault = 2;

  // Width of the saturating error counters.
  localparam int unsigned CntWidth = 8;

endpackage

// File: rtl/uart_host_satcnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module uart_host_satcnt
  import uart_host_pkg::*;
(
  input  logic                CLK,
  input  logic                clr_i,
  input  logic                inc_i,
  output logic [CntWidth-1:0] count_o
);

  logic [CntWidth-1:0] count_q;

  // Count up on inc_i, stick at the maximum instead of wrapping.
  always_ff @(posedge CLK) begin
    if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/uart_host_ctrl.sv
// Stream-to-CoreUART parallel-port initiator. Moves TX stream bytes into the
// core, pulls RX bytes out with parity/framing tags, round-robin between them.
// Optional error counters are built when UART_HOST_ERRCNT_EN is defined;
// otherwise OVF_CNT/PERR_CNT/FERR_CNT read as zero.
module uart_host_ctrl
  import uart_host_pkg::*;
#(
  parameter int unsigned HOLDOFF = HoldoffDefault
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [7:0]          TX_DATA,
  input  logic                TX_VALID,
  output logic                TX_READY,
  output logic [7:0]          RX_DATA,
  output logic                RX_PERR,
  output logic                RX_FERR,
  output logic                RX_VALID,
  input  logic                RX_READY,
  output logic                UART_CSN,
  output logic                UART_WEN,
  output logic                UART_OEN,
  output logic [7:0]          UART_DATA_IN,
  input  logic [7:0]          UART_DATA_OUT,
  input  logic                UART_TXRDY,
  input  logic                UART_RXRDY,
  input  logic                UART_PARITY_ERR,
  input  logic                UART_FRAMING_ERR,
  input  logic                UART_OVERFLOW,
  output logic [CntWidth-1:0] OVF_CNT,
  output logic [CntWidth-1:0] PERR_CNT,
  output logic [CntWidth-1:0] FERR_CNT
);

  localparam logic [2:0] HoldLoad = 3'(HOLDOFF - 1);

  state_e     state_q;
  logic [2:0] hold_cnt_q;
  logic       last_rx_q;
  logic       csn_q, wen_q, oen_q;
  logic [7:0] data_in_q;
  logic [7:0] rx_data_q;
  logic       rx_perr_q, rx_ferr_q, rx_valid_q;

  logic rx_req, tx_req, grant_rx, grant_tx;

  // Round-robin arbitration; last_rx_q records which side was served last.
  always_comb begin
    rx_req   = UART_RXRDY & ~rx_valid_q;
    tx_req   = TX_VALID & UART_TXRDY;
    grant_rx = (state_q == StIdle) & ~RESET & rx_req & (~tx_req | ~last_rx_q);
    grant_tx = (state_q == StIdle) & ~RESET & tx_req & (~rx_req | last_rx_q);
  end

  // Gated by RESET so no byte is accepted and then dropped by the reset edge.
  assign TX_READY = grant_tx;

  // Access sequencer with registered strobes and RX holding register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      last_rx_q  <= 1'b0;
      csn_q      <= 1'b1;
      wen_q      <= 1'b1;
      oen_q      <= 1'b1;
      data_in_q  <= '0;
      rx_data_q  <= '0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      if (rx_valid_q && RX_READY) begin
        rx_valid_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (grant_rx) begin
            state_q   <= StRead;
            csn_q     <= 1'b0;
            oen_q     <= 1'b0;
            last_rx_q <= 1'b1;
          end else if (grant_tx) begin
            state_q   <= StWrite;
            csn_q     <= 1'b0;
            wen_q     <= 1'b0;
            data_in_q <= TX_DATA;
            last_rx_q <= 1'b0;
          end
        end
        StWrite: begin
          csn_q      <= 1'b1;
          wen_q      <= 1'b1;
          hold_cnt_q <= HoldLoad;
          state_q    <= StHold;
        end
        StRead: begin
          csn_q      <= 1'b1;
          oen_q      <= 1'b1;
          rx_data_q  <= UART_DATA_OUT;
          rx_perr_q  <= UART_PARITY_ERR;
          rx_ferr_q  <= UART_FRAMING_ERR;
          rx_valid_q <= 1'b1;
          hold_cnt_q <= HoldLoad;
          state_q    <= StHold;
        end
        StHold: begin
          if (hold_cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            hold_cnt_q <= hold_cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign UART_CSN     = csn_q;
  assign UART_WEN     = wen_q;
  assign UART_OEN     = oen_q;
  assign UART_DATA_IN = data_in_q;
  assign RX_DATA      = rx_data_q;
  assign RX_PERR      = rx_perr_q;
  assign RX_FERR      = rx_ferr_q;
  assign RX_VALID     = rx_valid_q;

`ifdef UART_HOST_ERRCNT_EN
  logic ovf_q;
  logic ovf_inc, perr_inc, ferr_inc;

  // Previous OVERFLOW level for rising-edge detection.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= UART_OVERFLOW;
    end
  end

  // Error events: overflow edge, and tagged bytes on the READ cycle.
  always_comb begin
    ovf_inc  = UART_OVERFLOW & ~ovf_q;
    perr_inc = (state_q == StRead) & UART_PARITY_ERR;
    ferr_inc = (state_q == StRead) & UART_FRAMING_ERR;
  end

  uart_host_satcnt u_ovf_cnt (
    .CLK     (CLK),
    .clr_i   (RESET),
    .inc_i   (ovf_inc),
    .count_o (OVF_CNT)
  );

  uart_host_satcnt u_perr_cnt (
    .CLK     (CLK),
    .clr_i   (RESET),
    .inc_i   (perr_inc),
    .count_o (PERR_CNT)
  );

  uart_host_satcnt u_ferr_cnt (
    .CLK     (CLK),
    .clr_i   (RESET),
    .inc_i   (ferr_inc),
    .count_o (FERR_CNT)
  );
`else
  logic unused_ovf;
  assign unused_ovf = UART_OVERFLOW;
  assign OVF_CNT    = '0;
  assign PERR_CNT   = '0;
  assign FERR_CNT   = '0;
`endif

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Self-checking bench for uart_host_ctrl: directed scenarios plus a randomized
// run against a transaction-level model of the TX/RX byte streams.
module tb_uart_host_ctrl;

  localparam int unsigned H = 2;
`ifdef UART_HOST_ERRCNT_EN
  localparam bit ErrCntEn = 1'b1;
`else
  localparam bit ErrCntEn = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] TX_DATA;
  logic       TX_VALID, TX_READY;
  logic [7:0] RX_DATA;
  logic       RX_PERR, RX_FERR, RX_VALID, RX_READY;
  logic       UART_CSN, UART_WEN, UART_OEN;
  logic [7:0] UART_DATA_IN, UART_DATA_OUT;
  logic       UART_TXRDY, UART_RXRDY, UART_PARITY_ERR, UART_FRAMING_ERR, UART_OVERFLOW;
  logic [7:0] OVF_CNT, PERR_CNT, FERR_CNT;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  uart_host_ctrl #(.HOLDOFF(H)) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .TX_DATA          (TX_DATA),
    .TX_VALID         (TX_VALID),
    .TX_READY         (TX_READY),
    .RX_DATA          (RX_DATA),
    .RX_PERR          (RX_PERR),
    .RX_FERR          (RX_FERR),
    .RX_VALID         (RX_VALID),
    .RX_READY         (RX_READY),
    .UART_CSN         (UART_CSN),
    .UART_WEN         (UART_WEN),
    .UART_OEN         (UART_OEN),
    .UART_DATA_IN     (UART_DATA_IN),
    .UART_DATA_OUT    (UART_DATA_OUT),
    .UART_TXRDY       (UART_TXRDY),
    .UART_RXRDY       (UART_RXRDY),
    .UART_PARITY_ERR  (UART_PARITY_ERR),
    .UART_FRAMING_ERR (UART_FRAMING_ERR),
    .UART_OVERFLOW    (UART_OVERFLOW),
    .OVF_CNT          (OVF_CNT),
    .PERR_CNT         (PERR_CNT),
    .FERR_CNT         (FERR_CNT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int cnt_exp(input int v);
    return ErrCntEn ? sat(v) : 0;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    TX_DATA = '0; TX_VALID = 0; RX_READY = 0; UART_DATA_OUT = '0;
    UART_TXRDY = 0; UART_RXRDY = 0; UART_PARITY_ERR = 0; UART_FRAMING_ERR = 0;
    UART_OVERFLOW = 0;
  endtask

  task automatic do_reset();
    RESET = 1;
    idle_inputs();
    tick();
    tick();
    RESET = 0;
  endtask

  task automatic test_reset();
    RESET = 1;
    idle_inputs();
    TX_VALID = 1; UART_TXRDY = 1; TX_DATA = 8'hFF;
    tick();
    tick();
    n_checks++;
    if (TX_READY !== 1'b0) begin
      n_fail++; $display("FAIL reset_tx_ready: got %b, expected 0", TX_READY);
    end
    n_checks++;
    if (RX_VALID !== 1'b0) begin
      n_fail++; $display("FAIL reset_rx_valid: got %b, expected 0", RX_VALID);
    end
    n_checks++;
    if ({RX_DATA, RX_PERR, RX_FERR} !== 10'h0) begin
      n_fail++; $display("FAIL reset_rx_data: got %h/%b/%b, expected 00/0/0", RX_DATA, RX_PERR, RX_FERR);
    end
    n_checks++;
    if ({UART_CSN, UART_WEN, UART_OEN} !== 3'b111) begin
      n_fail++; $display("FAIL reset_strobes: got %b, expected 111", {UART_CSN, UART_WEN, UART_OEN});
    end
    n_checks++;
    if (UART_DATA_IN !== 8'h00) begin
      n_fail++; $display("FAIL reset_data_in: got %h, expected 00", UART_DATA_IN);
    end
    n_checks++;
    if ({OVF_CNT, PERR_CNT, FERR_CNT} !== 24'h0) begin
      n_fail++; $display("FAIL reset_counters: got %h %h %h, expected 0 0 0", OVF_CNT, PERR_CNT, FERR_CNT);
    end
    idle_inputs();
    RESET = 0;
  endtask

  task automatic test_single_tx();
    int got = -1;
    int early = 0;
    do_reset();
    UART_TXRDY = 1; TX_DATA = 8'hA5; TX_VALID = 1;
    #1;
    n_checks++;
    if (TX_READY !== 1'b1) begin
      n_fail++; $display("FAIL tx_ready_idle: got %b, expected 1", TX_READY);
    end
    tick();
    n_checks++;
    if ({UART_CSN, UART_WEN, UART_OEN} !== 3'b001 || UART_DATA_IN !== 8'hA5) begin
      n_fail++; $display("FAIL tx_write_cycle: got %b/%h, expected 001/a5",
                         {UART_CSN, UART_WEN, UART_OEN}, UART_DATA_IN);
    end
    TX_DATA = 8'h77;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (TX_READY === 1'b1) begin
        got = k;
        break;
      end
      if (UART_CSN !== 1'b1) early++;
    end
    n_checks++;
    if (got != int'(H) + 1) begin
      n_fail++; $display("FAIL tx_holdoff_gap: got %0d, expected %0d", got, H + 1);
    end
    n_checks++;
    if (early != 0) begin
      n_fail++; $display("FAIL tx_hold_strobes: got %0d strobe cycles, expected 0", early);
    end
    tick();
    TX_VALID = 0;
    n_checks++;
    if (UART_WEN !== 1'b0 || UART_DATA_IN !== 8'h77) begin
      n_fail++; $display("FAIL tx_second_write: got wen=%b data=%h, expected 0/77", UART_WEN, UART_DATA_IN);
    end
  endtask

  task automatic test_rx();
    int strobes = 0;
    int found = 0;
    do_reset();
    UART_DATA_OUT = 8'h3C; UART_RXRDY = 1;
    tick();
    n_checks++;
    if ({UART_CSN, UART_WEN, UART_OEN} !== 3'b010 || RX_VALID !== 1'b0) begin
      n_fail++; $display("FAIL rx_read_cycle: got %b rxv=%b, expected 010 rxv=0",
                         {UART_CSN, UART_WEN, UART_OEN}, RX_VALID);
    end
    tick();
    n_checks++;
    if (RX_VALID !== 1'b1 || RX_DATA !== 8'h3C) begin
      n_fail++; $display("FAIL rx_capture: got v=%b d=%h, expected 1/3c", RX_VALID, RX_DATA);
    end
    UART_DATA_OUT = 8'h99;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (UART_CSN !== 1'b1) strobes++;
    end
    n_checks++;
    if (strobes != 0 || RX_VALID !== 1'b1 || RX_DATA !== 8'h3C) begin
      n_fail++; $display("FAIL rx_no_overwrite: got strobes=%0d v=%b d=%h, expected 0/1/3c",
                         strobes, RX_VALID, RX_DATA);
    end
    RX_READY = 1;
    tick();
    RX_READY = 0;
    n_checks++;
    if (RX_VALID !== 1'b0) begin
      n_fail++; $display("FAIL rx_consume: got %b, expected 0", RX_VALID);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      if (UART_CSN === 1'b0) begin
        found = 1;
        break;
      end
    end
    UART_RXRDY = 0;
    tick();
    n_checks++;
    if (found != 1 || RX_DATA !== 8'h99) begin
      n_fail++; $display("FAIL rx_second_read: got found=%0d d=%h, expected 1/99", found, RX_DATA);
    end
    RX_READY = 1;
    tick();
    RX_READY = 0;
  endtask

  task automatic test_alternate();
    int last = -1;
    int idx = 0;
    int bad_kind = 0;
    int bad_gap = 0;
    do_reset();
    TX_VALID = 1; TX_DATA = 8'($urandom); UART_TXRDY = 1;
    UART_RXRDY = 1; RX_READY = 1; UART_DATA_OUT = 8'($urandom);
    for (int k = 0; k < 40; k++) begin
      tick();
      if (UART_CSN === 1'b0) begin
        // Even-numbered accesses are reads, odd ones writes.
        if ({UART_WEN, UART_OEN} !== ((idx % 2 == 1) ? 2'b01 : 2'b10)) bad_kind++;
        if (last >= 0 && cyc - last != int'(H) + 2) bad_gap++;
        last = cyc;
        idx++;
      end
    end
    n_checks++;
    if (bad_kind != 0) begin
      n_fail++; $display("FAIL alt_order: got %0d out-of-order accesses, expected 0", bad_kind);
    end
    n_checks++;
    if (bad_gap != 0) begin
      n_fail++; $display("FAIL alt_spacing: got %0d bad gaps, expected 0", bad_gap);
    end
    n_checks++;
    if (idx < 8) begin
      n_fail++; $display("FAIL alt_count: got %0d accesses, expected >= 8", idx);
    end
    idle_inputs();
  endtask

  task automatic test_parity();
    int found = 0;
    do_reset();
    UART_DATA_OUT = 8'h00; UART_PARITY_ERR = 1; UART_RXRDY = 1;
    for (int k = 0; k < 10 && found == 0; k++) begin
      tick();
      if (UART_CSN === 1'b0) found = 1;
    end
    UART_RXRDY = 0;
    tick();
    UART_PARITY_ERR = 0;
    n_checks++;
    if (found != 1 || {RX_VALID, RX_DATA, RX_PERR, RX_FERR} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL rx_perr_tag: got f=%0d v=%b d=%h p=%b f=%b, expected 1/1/00/1/0",
                         found, RX_VALID, RX_DATA, RX_PERR, RX_FERR);
    end
    n_checks++;
    if (int'(PERR_CNT) != cnt_exp(1) || int'(FERR_CNT) != 0) begin
      n_fail++; $display("FAIL perr_cnt: got %0d/%0d, expected %0d/0", PERR_CNT, FERR_CNT, cnt_exp(1));
    end
    RX_READY = 1;
    tick();
    RX_READY = 0;
    found = 0;
    UART_DATA_OUT = 8'hF0; UART_FRAMING_ERR = 1; UART_RXRDY = 1;
    for (int k = 0; k < 10 && found == 0; k++) begin
      tick();
      if (UART_CSN === 1'b0) found = 1;
    end
    UART_RXRDY = 0;
    tick();
    UART_FRAMING_ERR = 0;
    n_checks++;
    if (found != 1 || {RX_DATA, RX_PERR, RX_FERR} !== {8'hF0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL rx_ferr_tag: got f=%0d d=%h p=%b f=%b, expected 1/f0/0/1",
                         found, RX_DATA, RX_PERR, RX_FERR);
    end
    n_checks++;
    if (int'(FERR_CNT) != cnt_exp(1) || int'(PERR_CNT) != cnt_exp(1)) begin
      n_fail++; $display("FAIL ferr_cnt: got %0d/%0d, expected %0d/%0d",
                         FERR_CNT, PERR_CNT, cnt_exp(1), cnt_exp(1));
    end
    RX_READY = 1;
    tick();
    RX_READY = 0;
  endtask

  task automatic test_overflow_sat();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      UART_OVERFLOW = 1;
      tick();
      UART_OVERFLOW = 0;
      tick();
      if (i == 99) begin
        n_checks++;
        if (int'(OVF_CNT) != cnt_exp(100)) begin
          n_fail++; $display("FAIL ovf_cnt_100: got %0d, expected %0d", OVF_CNT, cnt_exp(100));
        end
      end
    end
    n_checks++;
    if (int'(OVF_CNT) != cnt_exp(300)) begin
      n_fail++; $display("FAIL ovf_cnt_sat: got %0d, expected %0d", OVF_CNT, cnt_exp(300));
    end
    n_checks++;
    if (PERR_CNT !== 8'h00 || FERR_CNT !== 8'h00) begin
      n_fail++; $display("FAIL ovf_crosstalk: got %0d/%0d, expected 0/0", PERR_CNT, FERR_CNT);
    end
  endtask

  task automatic test_reset_during_write();
    int strobes = 0;
    do_reset();
    UART_TXRDY = 1; TX_DATA = 8'h5A; TX_VALID = 1;
    tick();
    TX_VALID = 0;
    n_checks++;
    if (UART_WEN !== 1'b0) begin
      n_fail++; $display("FAIL rstw_in_write: got wen=%b, expected 0", UART_WEN);
    end
    RESET = 1;
    tick();
    n_checks++;
    if ({UART_CSN, UART_WEN, UART_OEN} !== 3'b111 || TX_READY !== 1'b0) begin
      n_fail++; $display("FAIL rstw_strobes: got %b rdy=%b, expected 111/0",
                         {UART_CSN, UART_WEN, UART_OEN}, TX_READY);
    end
    RESET = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (UART_CSN !== 1'b1) strobes++;
    end
    n_checks++;
    if (strobes != 0) begin
      n_fail++; $display("FAIL rstw_no_rewrite: got %0d strobe cycles, expected 0", strobes);
    end
    TX_DATA = 8'h11; TX_VALID = 1;
    #1;
    n_checks++;
    if (TX_READY !== 1'b1) begin
      n_fail++; $display("FAIL rstw_idle: got tx_ready=%b, expected 1", TX_READY);
    end
    tick();
    TX_VALID = 0;
    n_checks++;
    if (UART_WEN !== 1'b0 || UART_DATA_IN !== 8'h11) begin
      n_fail++; $display("FAIL rstw_new_write: got wen=%b d=%h, expected 0/11", UART_WEN, UART_DATA_IN);
    end
  endtask

  task automatic test_random();
    localparam int NTx = 40;
    localparam int NRx = 40;
    logic [7:0] tx_list [NTx];
    logic [7:0] rx_list [NRx];
    logic       pe_list [NRx];
    logic       fe_list [NRx];
    int tx_idx = 0, wr_idx = 0, rd_idx = 0, rx_got = 0;
    int last_acc = -1, nperr = 0, nferr = 0, budget = 0;
    bit adv = 0, tx_acc = 0;
    for (int i = 0; i < NTx; i++) tx_list[i] = 8'($urandom);
    for (int i = 0; i < NRx; i++) begin
      rx_list[i] = 8'($urandom);
      pe_list[i] = ($urandom_range(0, 3) == 0);
      fe_list[i] = ($urandom_range(0, 3) == 0);
    end
    do_reset();
    UART_DATA_OUT = rx_list[0]; UART_PARITY_ERR = pe_list[0]; UART_FRAMING_ERR = fe_list[0];
    while (budget < 4000 && !(wr_idx == NTx && rx_got == NRx)) begin
      tick();
      budget++;
      if (adv) begin
        adv = 0;
        if (rd_idx < NRx) begin
          UART_DATA_OUT = rx_list[rd_idx];
          UART_PARITY_ERR = pe_list[rd_idx];
          UART_FRAMING_ERR = fe_list[rd_idx];
        end
      end
      if (UART_CSN === 1'b0) begin
        n_checks++;
        if (last_acc >= 0 && cyc - last_acc < int'(H) + 2) begin
          n_fail++; $display("FAIL rand_spacing: got %0d, expected >= %0d", cyc - last_acc, H + 2);
        end
        last_acc = cyc;
        if (UART_WEN === 1'b0) begin
          n_checks++;
          if (wr_idx >= NTx || UART_OEN !== 1'b1 || UART_DATA_IN !== tx_list[wr_idx]) begin
            n_fail++; $display("FAIL rand_write: got %h oen=%b idx=%0d, expected %h oen=1",
                               UART_DATA_IN, UART_OEN, wr_idx, tx_list[wr_idx % NTx]);
          end
          wr_idx++;
        end else begin
          n_checks++;
          if (UART_OEN !== 1'b0 || RX_VALID !== 1'b0 || rd_idx >= NRx) begin
            n_fail++; $display("FAIL rand_read: got oen=%b rxv=%b idx=%0d, expected 0/0/<%0d",
                               UART_OEN, RX_VALID, rd_idx, NRx);
          end
          if (rd_idx < NRx) begin
            nperr += int'(pe_list[rd_idx]);
            nferr += int'(fe_list[rd_idx]);
          end
          rd_idx++;
          adv = 1;
        end
      end
      if (tx_acc) begin
        TX_VALID = 0;
        tx_acc = 0;
      end
      if (!TX_VALID && tx_idx < NTx && $urandom_range(0, 2) != 0) begin
        TX_VALID = 1;
        TX_DATA = tx_list[tx_idx];
      end
      UART_TXRDY = ($urandom_range(0, 3) != 0);
      UART_RXRDY = (rd_idx < NRx) && ($urandom_range(0, 2) != 0);
      RX_READY = 1'($urandom_range(0, 1));
      #1;
      if (TX_VALID && TX_READY) begin
        tx_idx++;
        tx_acc = 1;
      end
      if (RX_VALID && RX_READY) begin
        n_checks++;
        if (rx_got >= NRx ||
            {RX_DATA, RX_PERR, RX_FERR} !== {rx_list[rx_got], pe_list[rx_got], fe_list[rx_got]}) begin
          n_fail++; $display("FAIL rand_rx_byte %0d: got %h/%b/%b, expected %h/%b/%b", rx_got,
                             RX_DATA, RX_PERR, RX_FERR, rx_list[rx_got % NRx],
                             pe_list[rx_got % NRx], fe_list[rx_got % NRx]);
        end
        rx_got++;
      end
    end
    n_checks++;
    if (wr_idx != NTx || rx_got != NRx) begin
      n_fail++; $display("FAIL rand_totals: got wr=%0d rx=%0d, expected %0d/%0d", wr_idx, rx_got, NTx, NRx);
    end
    n_checks++;
    if (int'(PERR_CNT) != cnt_exp(nperr) || int'(FERR_CNT) != cnt_exp(nferr) || OVF_CNT !== 8'h00) begin
      n_fail++; $display("FAIL rand_counters: got %0d/%0d/%0d, expected %0d/%0d/0",
                         PERR_CNT, FERR_CNT, OVF_CNT, cnt_exp(nperr), cnt_exp(nferr));
    end
    idle_inputs();
  endtask

  initial begin
    RESET = 1;
    idle_inputs();
    test_reset();
    test_single_tx();
    test_rx();
    test_alternate();
    test_parity();
    test_overflow_sat();
    test_reset_during_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
